// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC sequencer with a single outstanding imem request,
// redirect/flush handling, HALT detection and a DEPTH-entry instruction queue for decode.
module fetch_queue #(
    parameter int                  ADDR_W    = 16,
    parameter int                  INSTR_W   = 16,
    parameter int                  DEPTH     = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [3:0]          HALT_OP   = 4'hF,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 16'hA000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc_inc,
    input  logic               id_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   pc_r, pc_s;
    logic                req_valid_s, enq_s, deq_s;
    logic [PTR_W-1:0]    head_r, tail_r;
    logic [CNT_W-1:0]    count_r;
    logic [INSTR_W-1:0]  q_instr_r [DEPTH];
    logic [ADDR_W-1:0]   q_pcinc_r [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Next-state, next-PC and queue push/pop decisions; redirect overrides everything.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        enq_s       = 1'b0;
        deq_s       = 1'b0;
        req_valid_s = (state_r == ST_REQ) && (count_r < CNT_W'(DEPTH)) && !redirect;
        if (redirect) begin
            pc_s = redirect_addr;
            // A response still in flight must be swallowed before fetching again.
            if (((state_r == ST_WAIT) || (state_r == ST_DRAIN)) && !imem_rsp_valid) begin
                state_s = ST_DRAIN;
            end else begin
                state_s = ST_REQ;
            end
        end else begin
            deq_s = (count_r != '0) && id_ready;
            case (state_r)
                ST_REQ: begin
                    if (req_valid_s && imem_req_ready) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        enq_s = 1'b1;
                        pc_s  = pc_r + ADDR_W'(2);
                        if (imem_rsp_data[INSTR_W-1 -: 4] == HALT_OP) begin
                            state_s = ST_HALT;
                        end else begin
                            state_s = ST_REQ;
                        end
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                ST_HALT: state_s = ST_HALT;
                default: state_s = ST_REQ;
            endcase
        end
    end

    // Sequencer state and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_REQ;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
        end
    end

    // Queue pointers and occupancy; a redirect flushes and discards any same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq_s) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (deq_s) begin
                head_r <= ptr_inc(head_r);
            end
            count_r <= count_r + CNT_W'(enq_s) - CNT_W'(deq_s);
        end
    end

    // Queue storage; the enqueued PC is the request address plus one instruction.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            q_instr_r[tail_r] <= imem_rsp_data;
            q_pcinc_r[tail_r] <= pc_r + ADDR_W'(2);
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign pc             = pc_r;
    assign halted         = (state_r == ST_HALT);
    assign instr_valid    = (count_r != '0);
    assign instr          = (count_r != '0) ? q_instr_r[head_r] : NOP_INSTR;
    assign instr_pc_inc   = (count_r != '0) ? q_pcinc_r[head_r] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a variable-latency memory and a queue-based
// reference model of the fetch rules predict every output each cycle.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] pci;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc_inc;
    logic        id_ready;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halted;
    logic [15:0] pc;

    always #5 clk = ~clk;

    fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc_inc   (instr_pc_inc),
        .id_ready       (id_ready),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr),
        .halted         (halted),
        .pc             (pc)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    logic [15:0] mem [256];

    // reference model
    logic [15:0] m_pc;
    bit          m_busy, m_stale, m_halt;
    ent_t        q[$];

    // memory model
    bit          mp;
    int          mw;
    logic [15:0] ma;

    initial begin
        bit          exp_rv;
        bit          after_rst;
        logic [15:0] tmp;
        logic [15:0] d;
        ent_t        e;

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        rst = 1'b1; redirect = 1'b0; redirect_addr = 16'h0000;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0000;
        id_ready = 1'b0;
        after_rst = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc < 2 || cyc == 2000) begin
                rst = 1'b1; redirect = 1'b0; imem_rsp_valid = 1'b0;
                id_ready = 1'b0; imem_req_ready = 1'b0;
                m_pc = 16'h0000; m_busy = 1'b0; m_stale = 1'b0; m_halt = 1'b0;
                q.delete();
                mp = 1'b0;
                after_rst = 1'b1;
                continue;
            end
            rst = 1'b0;

            if (after_rst) redirect = 1'b0;
            else if (m_halt) redirect = ($urandom % 4 == 0);
            else redirect = ($urandom % 16 == 0);
            after_rst = 1'b0;
            tmp = 16'($urandom);
            case ($urandom % 4)
                0:       redirect_addr = 16'hFFFE;
                1:       redirect_addr = 16'hFFFC;
                default: redirect_addr = {tmp[15:1], 1'b0};
            endcase
            imem_req_ready = (cyc % 300 < 30) ? 1'b0 : ($urandom % 3 != 0);
            id_ready       = ((cyc / 200) % 3 == 1) ? ($urandom % 10 == 0) : ($urandom % 4 != 0);
            imem_rsp_valid = mp && (mw == 0);
            imem_rsp_data  = imem_rsp_valid ? mem[ma[8:1]] : 16'($urandom);
            exp_rv = !m_busy && !m_stale && !m_halt && (q.size() < DEPTH) && !redirect;

            #1;
            chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
            if (exp_rv) chk("req_addr", {16'd0, imem_req_addr}, {16'd0, m_pc});
            chk("pc", {16'd0, pc}, {16'd0, m_pc});
            chk("halted", {31'd0, halted}, {31'd0, m_halt});
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
            e = (q.size() != 0) ? q[0] : {16'hA000, 16'h0000};
            chk("instr", {16'd0, instr}, {16'd0, e.ins});
            chk("pc_inc", {16'd0, instr_pc_inc}, {16'd0, e.pci});

            // memory answers whatever the DUT actually issued, 1..4 cycles later
            if (imem_rsp_valid) mp = 1'b0;
            else if (mp) mw--;
            if (imem_req_valid && imem_req_ready) begin
                mp = 1'b1;
                mw = $urandom_range(3, 0);
                ma = imem_req_addr;
            end

            // reference model update
            d = imem_rsp_data;
            if (redirect) begin
                q.delete();
                m_pc   = redirect_addr;
                m_halt = 1'b0;
                m_stale = (m_busy || m_stale) && !imem_rsp_valid;
                m_busy = 1'b0;
            end else begin
                if (q.size() != 0 && id_ready) void'(q.pop_front());
                if (m_busy && imem_rsp_valid) begin
                    q.push_back({d, 16'(m_pc + 16'd2)});
                    m_pc   = m_pc + 16'd2;
                    m_busy = 1'b0;
                    if (d[15:12] == 4'hF) m_halt = 1'b1;
                end else if (m_stale && imem_rsp_valid) begin
                    m_stale = 1'b0;
                end else if (exp_rv && imem_req_ready) begin
                    m_busy = 1'b1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
